// File: rtl/gp_register_file_if.sv
// Register-bus bundle between the decode/writeback stages (master) and the
// general-purpose register file (slave).
interface gp_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] i_rdAddrA;
    logic [DATA_WIDTH-1:0] o_rdDataA;
    logic [ADDR_WIDTH-1:0] i_rdAddrB;
    logic [DATA_WIDTH-1:0] o_rdDataB;
    logic [ADDR_WIDTH-1:0] i_wrAddr;
    logic [DATA_WIDTH-1:0] i_wrData;
    logic                  i_wrEnable;
    logic                  o_ready;

    modport master (
        output i_rdAddrA, i_rdAddrB, i_wrAddr, i_wrData, i_wrEnable,
        input  o_rdDataA, o_rdDataB, o_ready
    );

    modport slave (
        input  i_rdAddrA, i_rdAddrB, i_wrAddr, i_wrData, i_wrEnable,
        output o_rdDataA, o_rdDataB, o_ready
    );
endinterface

// File: rtl/gp_register_file.sv
// General-purpose register file: two combinational read ports, one write port,
// x0 hardwired to zero, storage cleared one entry per cycle after reset.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | writing 0 to reg[clr_cnt]; reads return 0, writes ignored
// ST_READY | normal operation, o_ready=1, stays here until reset
module gp_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT),
    parameter bit BYPASS     = 1'b1
) (
    input logic               i_clock,
    input logic               i_reset,
    gp_register_file_if.slave bus
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(REG_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    ready_q, ready_d;

    // Storage is intentionally not reset so it can map onto a RAM macro.
    logic [DATA_WIDTH-1:0]   mem_q [REG_COUNT];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    wr_live;
    logic [DATA_WIDTH-1:0]   rd_data_a;
    logic [DATA_WIDTH-1:0]   rd_data_b;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= FIRST_IDX;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end
            end
            ST_READY: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_CLEAR;
                ready_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_live   = (state_q == ST_READY) && bus.i_wrEnable && (bus.i_wrAddr != '0);
        mem_we    = 1'b0;
        mem_waddr = bus.i_wrAddr;
        mem_wdata = bus.i_wrData;
        // Reset must leave storage untouched, so every write is gated by it.
        if (i_reset) begin
            if (state_q == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
            end else begin
                mem_we = wr_live;
            end
        end
    end

    always_comb begin
        rd_data_a = '0;
        if ((state_q == ST_READY) && (bus.i_rdAddrA != '0)) begin
            if (BYPASS && bus.i_wrEnable && (bus.i_wrAddr == bus.i_rdAddrA)) begin
                rd_data_a = bus.i_wrData;
            end else begin
                rd_data_a = mem_q[bus.i_rdAddrA];
            end
        end
    end

    always_comb begin
        rd_data_b = '0;
        if ((state_q == ST_READY) && (bus.i_rdAddrB != '0)) begin
            if (BYPASS && bus.i_wrEnable && (bus.i_wrAddr == bus.i_rdAddrB)) begin
                rd_data_b = bus.i_wrData;
            end else begin
                rd_data_b = mem_q[bus.i_rdAddrB];
            end
        end
    end

    assign bus.o_rdDataA = rd_data_a;
    assign bus.o_rdDataB = rd_data_b;
    assign bus.o_ready   = ready_q;

endmodule

// File: tb/tb_gp_register_file.sv
// Bench for gp_register_file: a BYPASS=1 and a BYPASS=0 instance share one
// stimulus stream and are compared against a reference array model.
module tb_gp_register_file;

    typedef struct {
        string       tag;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic        rdy;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_a;
    logic [4:0]  rd_b;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;

    int          n_checks;
    int          n_errors;
    exp_t        sb_q[$];

    logic [31:0] ref_mem [32];
    logic        ref_ready;
    int          ref_cnt;

    gp_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus1 ();
    gp_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus0 ();

    assign bus1.i_rdAddrA  = rd_a;
    assign bus1.i_rdAddrB  = rd_b;
    assign bus1.i_wrAddr   = wr_addr;
    assign bus1.i_wrData   = wr_data;
    assign bus1.i_wrEnable = wr_en;
    assign bus0.i_rdAddrA  = rd_a;
    assign bus0.i_rdAddrB  = rd_b;
    assign bus0.i_wrAddr   = wr_addr;
    assign bus0.i_wrData   = wr_data;
    assign bus0.i_wrEnable = wr_en;

    gp_register_file #(.DATA_WIDTH(32), .REG_COUNT(32), .BYPASS(1'b1)) dut_byp (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus1)
    );

    gp_register_file #(.DATA_WIDTH(32), .REG_COUNT(32), .BYPASS(1'b0)) dut_nobyp (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] addr, input bit byp);
        if (!ref_ready || addr == 5'd0) return 32'h0;
        if (byp && wr_en && wr_addr == addr) return wr_data;
        return ref_mem[addr];
    endfunction

    task automatic tick_model();
        if (!rst_n) begin
            ref_ready = 1'b0;
            ref_cnt   = 1;
        end else if (!ref_ready) begin
            ref_mem[ref_cnt] = 32'h0;
            if (ref_cnt == 31) ref_ready = 1'b1;
            ref_cnt++;
        end else if (wr_en && wr_addr != 5'd0) begin
            ref_mem[wr_addr] = wr_data;
        end
    endtask

    // Inputs are already applied (after a falling edge); sample, compare,
    // advance the model across the coming rising edge, wait for next fall.
    task automatic step(input string tag);
        exp_t e;
        #1;
        sb_q.push_back('{tag: tag, a1: exp_rd(rd_a, 1'b1), b1: exp_rd(rd_b, 1'b1),
                         a0: exp_rd(rd_a, 1'b0), b0: exp_rd(rd_b, 1'b0), rdy: ref_ready});
        e = sb_q.pop_front();
        check({e.tag, ":a_byp"},   bus1.o_rdDataA, e.a1);
        check({e.tag, ":b_byp"},   bus1.o_rdDataB, e.b1);
        check({e.tag, ":a_nobyp"}, bus0.o_rdDataA, e.a0);
        check({e.tag, ":b_nobyp"}, bus0.o_rdDataB, e.b0);
        check({e.tag, ":ready"},   {31'b0, bus1.o_ready}, {31'b0, e.rdy});
        check({e.tag, ":ready0"},  {31'b0, bus0.o_ready}, {31'b0, e.rdy});
        tick_model();
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        rst_n   = 1'b0;
        rd_a    = '0;
        rd_b    = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_en   = 1'b0;

        // Two reset edges, then release.
        @(negedge clk);
        @(negedge clk);
        ref_ready = 1'b0;
        ref_cnt   = 1;
        #1;
        check("rst_ready", {31'b0, bus1.o_ready}, 32'h0);
        check("rst_rd_a",  bus1.o_rdDataA, 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            rd_a = 5'(k);
            step("clr");
        end
        check("ready_31", {31'b0, bus1.o_ready}, 32'h1);
        for (int i = 0; i < 32; i++) begin
            rd_a = 5'(i);
            rd_b = 5'(31 - i);
            step("zero");
        end

        // Write then read back on both ports; x0 writes are dropped.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_a = 5'd1; rd_b = 5'd2;
        step("w5");
        wr_en = 1'b0; rd_a = 5'd5; rd_b = 5'd5;
        #1;
        check("x5_a", bus1.o_rdDataA, 32'hDEADBEEF);
        check("x5_b", bus1.o_rdDataB, 32'hDEADBEEF);
        step("r5");
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rd_a = 5'd0; rd_b = 5'd0;
        #1;
        check("x0_wr_a", bus1.o_rdDataA, 32'h0);
        step("w0");
        wr_en = 1'b0;
        #1;
        check("x0_rd_a", bus1.o_rdDataA, 32'h0);
        step("r0");

        // Same-cycle bypass vs. no-bypass.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000001;
        step("w7");
        wr_addr = 5'd8; wr_data = 32'h00000088;
        step("w8");
        wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rd_a = 5'd7; rd_b = 5'd8;
        #1;
        check("byp_a",   bus1.o_rdDataA, 32'hA5A5A5A5);
        check("byp_b",   bus1.o_rdDataB, 32'h00000088);
        check("nobyp_a", bus0.o_rdDataA, 32'h00000001);
        check("nobyp_b", bus0.o_rdDataB, 32'h00000088);
        step("byp");
        wr_en = 1'b0;
        #1;
        check("byp_next_a",   bus1.o_rdDataA, 32'hA5A5A5A5);
        check("nobyp_next_a", bus0.o_rdDataA, 32'hA5A5A5A5);
        step("byp_next");

        // Put a nonzero value in x3, then reset mid-clear and write x3 during CLEAR.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0BADF00D;
        step("w3");
        wr_en = 1'b0;
        rst_n = 1'b0;
        step("rst2");
        rst_n = 1'b1;
        repeat (10) step("clr2");
        rst_n = 1'b0;
        step("rst3");
        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h000000FF; rd_a = 5'd3; rd_b = 5'd3;
        cnt = 0;
        while (bus1.o_ready !== 1'b1 && cnt < 100) begin
            step("clr3");
            cnt++;
        end
        check("clr_len", 32'(cnt), 32'd31);
        wr_en = 1'b0;
        #1;
        check("x3_after_clr_a", bus1.o_rdDataA, 32'h0);
        check("x3_after_clr_b", bus0.o_rdDataB, 32'h0);
        step("x3");

        // Random regression in READY.
        for (int n = 0; n < 10000; n++) begin
            rd_a    = 5'($urandom_range(0, 31));
            rd_b    = ($urandom_range(0, 3) == 0) ? rd_a : 5'($urandom_range(0, 31));
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = ($urandom_range(0, 3) == 0) ? rd_a : 5'($urandom_range(0, 31));
            wr_data = $urandom;
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
